// File: rtl/column_scheduler_if.sv
// Handshake bundle between the game controller and the three falling-letter columns.
// The scheduler takes the master side; the board/columns take the slave side.
interface column_scheduler_if;
  logic       start;
  logic [2:0] game_over;
  logic [2:0] correct;
  logic [2:0] column_reset;
  logic [2:0] column_enable;
  logic [7:0] score;
  logic [1:0] level;
  logic [1:0] state;

  modport master (
    input  start, game_over, correct,
    output column_reset, column_enable, score, level, state
  );

  modport slave (
    output start, game_over, correct,
    input  column_reset, column_enable, score, level, state
  );
endinterface

// File: rtl/column_scheduler.sv
// Game controller: launches three columns staggered by LAUNCH_GAP cycles, re-arms a column
// on each correct answer, keeps a saturating score/level and freezes play on game over.
module column_scheduler #(
  parameter int LAUNCH_GAP = 50_000_000,
  parameter int LEVEL_STEP = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  column_scheduler_if.master         bus
);

  localparam int GAP_W     = (LAUNCH_GAP > 1) ? $clog2(LAUNCH_GAP) : 1;
  localparam int LVL_SHIFT = $clog2(LEVEL_STEP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(LAUNCH_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  state_e           state_q;
  logic [GAP_W-1:0] gap_q;
  logic [1:0]       launch_idx_q;
  logic [2:0]       correct_hist_q;
  logic [2:0]       col_reset_q;
  logic [2:0]       col_en_q;
  logic [7:0]       score_q;
  logic [1:0]       level_q;

  logic [2:0] correct_rise;
  logic       over_hit;
  logic       launch_now;
  logic [2:0] launch_mask;
  logic [9:0] rise_cnt;
  logic [9:0] score_sum;
  logic [7:0] score_d;
  logic [7:0] level_shifted;
  logic [1:0] level_d;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    correct_rise  = '0;
    over_hit      = 1'b0;
    launch_now    = 1'b0;
    launch_mask   = '0;
    rise_cnt      = '0;
    score_sum     = '0;
    score_d       = '0;
    level_shifted = '0;
    level_d       = '0;

    // Only rising edges on columns that are already live count as answers.
    correct_rise = bus.correct & ~correct_hist_q & col_en_q;
    over_hit     = |(bus.game_over & col_en_q);

    launch_now  = (state_q == ST_LAUNCH) && (gap_q == GAP_LAST);
    launch_mask = launch_now ? (3'b001 << launch_idx_q) : 3'b000;

    rise_cnt  = 10'(correct_rise[0]) + 10'(correct_rise[1]) + 10'(correct_rise[2]);
    score_sum = {2'b00, score_q} + rise_cnt;
    score_d   = (score_sum > 10'd255) ? 8'hFF : score_sum[7:0];

    level_shifted = score_d >> LVL_SHIFT;
    level_d       = (level_shifted > 8'd3) ? 2'd3 : level_shifted[1:0];
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      gap_q          <= '0;
      launch_idx_q   <= '0;
      correct_hist_q <= '0;
      col_reset_q    <= '0;
      col_en_q       <= '0;
      score_q        <= '0;
      level_q        <= '0;
    end else begin
      correct_hist_q <= bus.correct;
      col_reset_q    <= '0;

      case (state_q)
        ST_IDLE, ST_OVER: begin
          if (bus.start) begin
            state_q      <= ST_LAUNCH;
            score_q      <= '0;
            level_q      <= '0;
            col_reset_q  <= 3'b001;
            col_en_q     <= 3'b001;
            gap_q        <= '0;
            launch_idx_q <= 2'd1;
          end
        end

        ST_LAUNCH, ST_RUN: begin
          if (over_hit) begin
            // Game over wins over any same-cycle answer or launch.
            state_q  <= ST_OVER;
            col_en_q <= '0;
          end else begin
            col_reset_q <= correct_rise | launch_mask;
            col_en_q    <= col_en_q | launch_mask;
            score_q     <= score_d;
            level_q     <= level_d;

            if (state_q == ST_LAUNCH) begin
              if (launch_now) begin
                gap_q        <= '0;
                launch_idx_q <= launch_idx_q + 2'd1;
                if (launch_idx_q == 2'd2) begin
                  state_q <= ST_RUN;
                end
              end else begin
                gap_q <= gap_q + GAP_W'(1);
              end
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.column_reset  = col_reset_q;
  assign bus.column_enable = col_en_q;
  assign bus.score         = score_q;
  assign bus.level         = level_q;
  assign bus.state         = state_q;

endmodule
